// File: rtl/udp_vlg_pkg.sv
// Shared types for the UDP transmit path: stream beats, UDP/IPv4 metadata,
// the transmit FSM encoding and the UDP header byte serializer.
package udp_vlg_pkg;

  localparam int         UDP_HDR_LEN = 8;
  localparam logic [7:0] UDP_PROTO   = 8'h11;

  typedef struct packed {
    logic [7:0] dat;
    logic       val;
    logic       sof;
    logic       eof;
    logic       err;
  } stream_t;

  typedef struct packed {
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] length;
    logic [31:0] ip;
    logic        mac_known;
  } udp_meta_t;

  typedef struct packed {
    logic [7:0]  proto;
    logic [15:0] length;
    logic [31:0] ip;
    logic        mac_known;
  } ipv4_meta_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_REQ,
    HDR,
    PLD,
    DONE
  } udp_tx_fsm_t;

  // Checksum bytes (6, 7) are sent as zero: the UDP checksum is optional over IPv4.
  function automatic logic [7:0] hdr_byte(input udp_meta_t m, input logic [2:0] idx);
    logic [15:0] udp_len;
    udp_len = m.length + 16'(UDP_HDR_LEN);
    case (idx)
      3'd0:    hdr_byte = m.src_port[15:8];
      3'd1:    hdr_byte = m.src_port[7:0];
      3'd2:    hdr_byte = m.dst_port[15:8];
      3'd3:    hdr_byte = m.dst_port[7:0];
      3'd4:    hdr_byte = udp_len[15:8];
      3'd5:    hdr_byte = udp_len[7:0];
      default: hdr_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/udp_vlg_tx.sv
// UDP transmit engine: latches user metadata, requests an IPv4 slot, emits the
// 8-byte UDP header and then forwards the user payload without bubbles.
module udp_vlg_tx
  import udp_vlg_pkg::*;
#(
  parameter int TIMEOUT = 65535,
  parameter int VERBOSE = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  stream_t    udp_strm,
  input  udp_meta_t  udp_meta,
  input  logic       udp_rdy,
  output logic       udp_req,
  output logic       udp_ack,
  output logic       udp_done,
  output stream_t    ipv4_strm,
  output ipv4_meta_t ipv4_meta,
  output logic       ipv4_rdy,
  input  logic       ipv4_req,
  input  logic       ipv4_ack,
  input  logic       ipv4_err
);

  udp_tx_fsm_t state_q, state_d;
  udp_meta_t   meta_q, meta_d;
  ipv4_meta_t  ipv4_meta_q, ipv4_meta_d;
  stream_t     strm_q, strm_d;
  logic        ipv4_rdy_q, ipv4_rdy_d;
  logic        udp_req_q, udp_req_d;
  logic        udp_done_q, udp_done_d;
  logic        udp_ack_q, udp_ack_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic [16:0] timer_q, timer_d;

  logic pulling;
  logic abort_now;
  logic last_cnt;

  // Payload is pulled from the cycle header byte 7 is on the bus onwards.
  assign pulling  = (state_q == PLD) ||
                    (state_q == HDR && idx_q == 3'd7 && meta_q.length != 16'd0);
  assign last_cnt = (cnt_q + 16'd1) == meta_q.length;

  // An IPv4 abort or a user gap terminates on the byte already on the bus,
  // so eof/err are folded onto the registered beat in the same cycle.
  assign abort_now = (state_q == HDR || state_q == PLD) && strm_q.val && !strm_q.eof &&
                     (ipv4_err || (pulling && !udp_strm.val));

  // NOTE: every _d gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    meta_d      = meta_q;
    ipv4_meta_d = ipv4_meta_q;
    ipv4_rdy_d  = ipv4_rdy_q;
    udp_req_d   = udp_req_q;
    udp_done_d  = 1'b0;
    udp_ack_d   = ipv4_ack;
    strm_d      = '0;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    timer_d     = timer_q;
    case (state_q)
      IDLE: begin
        if (udp_rdy) begin
          meta_d      = udp_meta;
          ipv4_meta_d = '{proto: UDP_PROTO, length: udp_meta.length + 16'(UDP_HDR_LEN),
                          ip: udp_meta.ip, mac_known: udp_meta.mac_known};
          ipv4_rdy_d  = 1'b1;
          timer_d     = '0;
          state_d     = WAIT_REQ;
        end
      end
      WAIT_REQ: begin
        if (ipv4_req) begin
          ipv4_rdy_d = 1'b0;
          idx_d      = 3'd0;
          cnt_d      = '0;
          strm_d     = '{dat: hdr_byte(meta_q, 3'd0), val: 1'b1, sof: 1'b1, eof: 1'b0, err: 1'b0};
          state_d    = HDR;
        end else if (ipv4_err || (int'(timer_q) + 1 >= TIMEOUT)) begin
          ipv4_rdy_d = 1'b0;
          udp_done_d = 1'b1;
          state_d    = DONE;
        end else begin
          timer_d = timer_q + 17'd1;
        end
      end
      HDR, PLD: begin
        if (strm_q.eof || abort_now) begin
          udp_req_d  = 1'b0;
          udp_done_d = 1'b1;
          state_d    = DONE;
        end else if (pulling) begin
          cnt_d   = cnt_q + 16'd1;
          strm_d  = '{dat: udp_strm.dat, val: 1'b1, sof: 1'b0,
                      eof: last_cnt || udp_strm.eof, err: last_cnt != udp_strm.eof};
          state_d = PLD;
          if (last_cnt || udp_strm.eof) udp_req_d = 1'b0;
        end else begin
          idx_d  = idx_q + 3'd1;
          strm_d = '{dat: hdr_byte(meta_q, idx_q + 3'd1), val: 1'b1, sof: 1'b0,
                     eof: idx_q == 3'd6 && meta_q.length == 16'd0, err: 1'b0};
          // Request one cycle early so a registered user lands its first byte behind byte 7.
          if (idx_q == 3'd5 && meta_q.length != 16'd0) udp_req_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      meta_q      <= '0;
      ipv4_meta_q <= '0;
      strm_q      <= '0;
      ipv4_rdy_q  <= 1'b0;
      udp_req_q   <= 1'b0;
      udp_done_q  <= 1'b0;
      udp_ack_q   <= 1'b0;
      idx_q       <= '0;
      cnt_q       <= '0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      meta_q      <= meta_d;
      ipv4_meta_q <= ipv4_meta_d;
      strm_q      <= strm_d;
      ipv4_rdy_q  <= ipv4_rdy_d;
      udp_req_q   <= udp_req_d;
      udp_done_q  <= udp_done_d;
      udp_ack_q   <= udp_ack_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      timer_q     <= timer_d;
    end
  end

  always_comb begin
    ipv4_strm     = strm_q;
    ipv4_strm.eof = strm_q.eof | abort_now;
    ipv4_strm.err = strm_q.err | abort_now;
  end

  assign ipv4_meta = ipv4_meta_q;
  assign ipv4_rdy  = ipv4_rdy_q;
  assign udp_req   = udp_req_q;
  assign udp_done  = udp_done_q;
  assign udp_ack   = udp_ack_q;

  // Framing is driven by the latched length, so user sof/err and the
  // IPv4-only metadata fields kept in meta_q are not consumed here.
  logic unused_ok;
  assign unused_ok = &{1'b0, udp_strm.sof, udp_strm.err, meta_q.ip, meta_q.mac_known};

  // Datagram trace hook: simulation-only diagnostics, no hardware.
  if (VERBOSE != 0) begin : g_verbose
  end

endmodule

// File: tb/tb_udp_vlg_tx.sv
// Directed bench for udp_vlg_tx: a cycle-stepped user/IPv4 driver plus
// per-scenario tasks that compare captured beats with hand-computed bytes.
module tb_udp_vlg_tx;
  import udp_vlg_pkg::*;

  localparam logic [31:0] DST_IP = 32'hC0A8_0A01;

  logic       clk = 1'b0;
  logic       rst;
  stream_t    udp_strm;
  udp_meta_t  udp_meta;
  logic       udp_rdy, udp_req, udp_ack, udp_done;
  stream_t    ipv4_strm;
  ipv4_meta_t ipv4_meta;
  logic       ipv4_rdy, ipv4_req, ipv4_ack, ipv4_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] cap_dat[$];
  logic [2:0] cap_flg[$];
  int         cap_cyc[$];
  int         rdy_cycles, last_rdy_cyc, done_cnt, done_cyc, ack_cyc, ack_drv_cyc;
  bit         req_seen, timed_out;
  ipv4_meta_t meta_seen;
  stream_t    rst_strm;
  logic [3:0] rst_ctl;
  ipv4_meta_t rst_meta;

  always #5 clk = ~clk;

  udp_vlg_tx #(.TIMEOUT(16), .VERBOSE(0)) dut (
    .clk(clk), .rst(rst),
    .udp_strm(udp_strm), .udp_meta(udp_meta), .udp_rdy(udp_rdy),
    .udp_req(udp_req), .udp_ack(udp_ack), .udp_done(udp_done),
    .ipv4_strm(ipv4_strm), .ipv4_meta(ipv4_meta), .ipv4_rdy(ipv4_rdy),
    .ipv4_req(ipv4_req), .ipv4_ack(ipv4_ack), .ipv4_err(ipv4_err)
  );

  task automatic idle_inputs();
    udp_strm = '0; udp_meta = '0; udp_rdy = 1'b0;
    ipv4_req = 1'b0; ipv4_ack = 1'b0; ipv4_err = 1'b0;
  endtask

  // One datagram: udp_rdy for one cycle, ipv4_req/ack req_delay cycles into ipv4_rdy
  // (-1 = never), user bytes 01.. after each observed udp_req, optional ipv4_err on
  // output beat err_idx and reset on output beat rst_idx (-1 = none).
  task automatic run_frame(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len,
                           input int n_user, input bit user_eof, input int req_delay,
                           input int err_idx, input int rst_idx);
    int cyc, sent, tail;
    bit req_given, req_prev;
    cap_dat.delete(); cap_flg.delete(); cap_cyc.delete();
    rdy_cycles = 0; last_rdy_cyc = -1; done_cnt = 0; done_cyc = -1;
    ack_cyc = -1; ack_drv_cyc = -1; req_seen = 0; timed_out = 0; meta_seen = '0;
    cyc = 0; sent = 0; tail = -1; req_given = 0; req_prev = 0;
    while (1) begin
      @(posedge clk); #1;
      if (rst_idx >= 0 && ipv4_strm.val && cap_dat.size() == rst_idx) begin
        rst = 1'b1; #1;
        rst_strm = ipv4_strm;
        rst_ctl  = {ipv4_rdy, udp_req, udp_done, udp_ack};
        rst_meta = ipv4_meta;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        break;
      end
      udp_rdy  = (cyc == 0);
      udp_meta = (cyc == 0) ? '{src_port: src, dst_port: dst, length: len, ip: DST_IP, mac_known: 1'b1}
                            : '1;
      ipv4_req = 1'b0;
      ipv4_ack = 1'b0;
      if (!req_given && req_delay >= 0 && ipv4_rdy && rdy_cycles >= req_delay) begin
        ipv4_req = 1'b1; ipv4_ack = 1'b1; req_given = 1; ack_drv_cyc = cyc;
      end
      ipv4_err = (err_idx >= 0 && ipv4_strm.val && cap_dat.size() == err_idx);
      udp_strm = '0;
      if (req_prev && sent < n_user) begin
        udp_strm.dat = 8'(sent + 1);
        udp_strm.val = 1'b1;
        udp_strm.sof = (sent == 0);
        udp_strm.eof = user_eof && (sent == n_user - 1);
        sent++;
      end
      @(negedge clk);
      if (ipv4_strm.val) begin
        cap_dat.push_back(ipv4_strm.dat);
        cap_flg.push_back({ipv4_strm.sof, ipv4_strm.eof, ipv4_strm.err});
        cap_cyc.push_back(cyc);
      end
      if (ipv4_rdy) begin rdy_cycles++; last_rdy_cyc = cyc; meta_seen = ipv4_meta; end
      if (udp_req) req_seen = 1;
      req_prev = udp_req;
      if (udp_ack) ack_cyc = cyc;
      if (udp_done) begin done_cnt++; done_cyc = cyc; if (tail < 0) tail = 3; end
      cyc++;
      if (tail > 0) begin tail--; if (tail == 0) break; end
      if (cyc >= 400) begin timed_out = 1; break; end
    end
    idle_inputs();
    checks++;
    if (timed_out) begin
      errors++;
      $display("FAIL frame_timeout: udp_done not seen within %0d cycles", cyc);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({ipv4_strm, ipv4_meta, ipv4_rdy, udp_req, udp_done, udp_ack} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: strm=%h meta=%h rdy=%b req=%b done=%b ack=%b required all 0",
               ipv4_strm, ipv4_meta, ipv4_rdy, udp_req, udp_done, udp_ack);
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] exp [12];
    logic [2:0] ef;
    exp = '{8'h03, 8'hE8, 8'h07, 8'hD0, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    run_frame(16'd1000, 16'd2000, 16'd4, 4, 1'b1, 2, -1, -1);
    checks++;
    if (cap_dat.size() != 12) begin
      errors++; $display("FAIL basic_count: got %0d bytes required 12", cap_dat.size());
    end
    for (int i = 0; i < cap_dat.size() && i < 12; i++) begin
      ef = {i == 0, i == 11, 1'b0};
      checks++;
      if (cap_dat[i] !== exp[i] || cap_flg[i] !== ef || cap_cyc[i] != cap_cyc[0] + i) begin
        errors++;
        $display("FAIL basic_byte%0d: got %h sof/eof/err=%b cyc=%0d required %h %b cyc=%0d",
                 i, cap_dat[i], cap_flg[i], cap_cyc[i], exp[i], ef, cap_cyc[0] + i);
      end
    end
    checks++;
    if (meta_seen !== '{proto: 8'h11, length: 16'd12, ip: DST_IP, mac_known: 1'b1}) begin
      errors++; $display("FAIL basic_meta: got %h required proto 11 len 000c ip %h mac 1", meta_seen, DST_IP);
    end
    checks++;
    if (cap_cyc.size() == 12 && (done_cnt != 1 || done_cyc != cap_cyc[11] + 1)) begin
      errors++; $display("FAIL basic_done: got %0d pulses at cyc %0d required 1 at cyc %0d", done_cnt, done_cyc, cap_cyc[11] + 1);
    end
    checks++;
    if (ack_cyc != ack_drv_cyc + 1 || rdy_cycles != 3 || !req_seen) begin
      errors++;
      $display("FAIL basic_handshake: ack_cyc=%0d rdy_cycles=%0d req=%0b required ack_cyc=%0d rdy_cycles=3 req=1",
               ack_cyc, rdy_cycles, req_seen, ack_drv_cyc + 1);
    end
  endtask

  task automatic test_zero_len();
    logic [7:0] exp [8];
    exp = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h08, 8'h00, 8'h00};
    run_frame(16'h1234, 16'hABCD, 16'd0, 0, 1'b0, 0, -1, -1);
    checks++;
    if (cap_dat.size() != 8 || req_seen || meta_seen.length !== 16'd8) begin
      errors++; $display("FAIL zero_len_frame: got %0d bytes req=%0b len=%h required 8 bytes req=0 len=0008",
                         cap_dat.size(), req_seen, meta_seen.length);
    end
    for (int i = 0; i < cap_dat.size() && i < 8; i++) begin
      checks++;
      if (cap_dat[i] !== exp[i] || cap_flg[i] !== {i == 0, i == 7, 1'b0}) begin
        errors++; $display("FAIL zero_len_byte%0d: got %h %b required %h %b", i, cap_dat[i], cap_flg[i], exp[i], {i == 0, i == 7, 1'b0});
      end
    end
    checks++;
    if (cap_cyc.size() == 8 && (done_cnt != 1 || done_cyc != cap_cyc[7] + 1)) begin
      errors++; $display("FAIL zero_len_done: got %0d pulses at cyc %0d required 1 at cyc %0d", done_cnt, done_cyc, cap_cyc[7] + 1);
    end
  endtask

  task automatic test_timeout();
    // length FFFC also checks that udp_len wraps to 0004 in the IPv4 metadata
    run_frame(16'd1, 16'd2, 16'hFFFC, 0, 1'b0, -1, -1, -1);
    checks++;
    if (rdy_cycles != 16 || cap_dat.size() != 0) begin
      errors++; $display("FAIL timeout_rdy: got rdy %0d cycles, %0d bytes required 16 cycles, 0 bytes", rdy_cycles, cap_dat.size());
    end
    checks++;
    if (done_cnt != 1 || done_cyc != last_rdy_cyc + 1) begin
      errors++; $display("FAIL timeout_done: got %0d pulses at cyc %0d required 1 at cyc %0d", done_cnt, done_cyc, last_rdy_cyc + 1);
    end
    checks++;
    if (meta_seen.length !== 16'h0004) begin
      errors++; $display("FAIL timeout_len_wrap: got %h required 0004", meta_seen.length);
    end
  endtask

  task automatic test_early_eof();
    run_frame(16'd1000, 16'd2000, 16'd4, 2, 1'b1, 1, -1, -1);
    checks++;
    if (cap_dat.size() != 10) begin
      errors++; $display("FAIL early_eof_count: got %0d bytes required 10", cap_dat.size());
    end else begin
      checks++;
      if (cap_dat[8] !== 8'h01 || cap_flg[8] !== 3'b000 || cap_dat[9] !== 8'h02 || cap_flg[9] !== 3'b011) begin
        errors++; $display("FAIL early_eof_tail: got %h/%b %h/%b required 01/000 02/011",
                           cap_dat[8], cap_flg[8], cap_dat[9], cap_flg[9]);
      end
      checks++;
      if (done_cyc != cap_cyc[9] + 1) begin
        errors++; $display("FAIL early_eof_done: got cyc %0d required %0d", done_cyc, cap_cyc[9] + 1);
      end
    end
  endtask

  task automatic test_ipv4_err();
    run_frame(16'd1000, 16'd2000, 16'd4, 4, 1'b1, 1, 9, -1);
    checks++;
    if (cap_dat.size() != 10) begin
      errors++; $display("FAIL ipv4_err_count: got %0d bytes required 10", cap_dat.size());
    end else begin
      checks++;
      if (cap_dat[9] !== 8'h02 || cap_flg[9] !== 3'b011 || cap_flg[8] !== 3'b000) begin
        errors++; $display("FAIL ipv4_err_tail: got %h/%b prev %b required 02/011 prev 000", cap_dat[9], cap_flg[9], cap_flg[8]);
      end
      checks++;
      if (done_cnt != 1 || done_cyc != cap_cyc[9] + 1) begin
        errors++; $display("FAIL ipv4_err_done: got %0d pulses at cyc %0d required 1 at cyc %0d", done_cnt, done_cyc, cap_cyc[9] + 1);
      end
    end
  endtask

  task automatic test_rst_mid_frame();
    run_frame(16'd1000, 16'd2000, 16'd4, 4, 1'b1, 0, -1, 3);
    checks++;
    if (rst_strm !== '0 || rst_ctl !== 4'b0000 || rst_meta !== '0) begin
      errors++; $display("FAIL rst_mid_outputs: strm=%h ctl=%b meta=%h required all 0", rst_strm, rst_ctl, rst_meta);
    end
    run_frame(16'h0102, 16'h0304, 16'd2, 2, 1'b1, 0, -1, -1);
    checks++;
    if (cap_dat.size() != 10 || cap_dat[0] !== 8'h01 || cap_flg[0] !== 3'b100 || cap_dat[5] !== 8'h0A
        || cap_dat[9] !== 8'h02 || cap_flg[9] !== 3'b010 || done_cnt != 1) begin
      errors++; $display("FAIL rst_mid_recover: got %0d bytes first %h last %h/%b done %0d required 10 bytes 01 .. 02/010 done 1",
                         cap_dat.size(), cap_dat[0], cap_dat[cap_dat.size()-1], cap_flg[cap_flg.size()-1], done_cnt);
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    test_reset();
    test_basic();
    test_zero_len();
    test_timeout();
    test_early_eof();
    test_ipv4_err();
    test_rst_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
